// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//  - Access size encodings carried on req_size.
//  - Controller state enumeration.
//  - Byte-lane helpers used by the alignment network and the error check.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_STORE  = 3'd3,
        ST_DONE   = 3'd4
    } lsu_state_t;

    // Byte lanes of the memory word touched by an access of the given size.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Alignment violation; the illegal size code is folded in here as well.
    function automatic logic bad_align(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment shared by the LOAD and RMW_RD states.
// Ports:
//  word_in     in  32  word read from memory
//  addr_lo     in  2   byte offset within the word
//  size        in  2   access size (lsu_pkg SZ_*)
//  is_unsigned in  1   1 zero-extend, 0 sign-extend (loads)
//  wdata       in  32  right-justified store data
//  load_data   out 32  extracted and extended load value
//  merged      out 32  word_in with the store lanes replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] repl_s;
    logic [3:0]  mask_s;

    // Lane selection for byte and half loads.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = word_in[7:0];
            2'd1:    byte_s = word_in[15:8];
            2'd2:    byte_s = word_in[23:16];
            2'd3:    byte_s = word_in[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo[1] ? word_in[31:16] : word_in[15:0];
    end

    // Sign/zero extension of the selected lane.
    always_comb begin
        load_data = 32'h0000_0000;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: load_data = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            SZ_WORD: load_data = word_in;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store merge: replicate the store data into every lane, then keep only the target lanes.
    always_comb begin
        mask_s = lane_mask(size, addr_lo);
        case (size)
            SZ_BYTE: repl_s = {4{wdata[7:0]}};
            SZ_HALF: repl_s = {2{wdata[15:0]}};
            default: repl_s = wdata;
        endcase
        merged = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = mask_s[i] ? repl_s[8*i +: 8] : word_in[8*i +: 8];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding initiator for the word-addressed data memory.
// Byte/half/word loads are lane-extracted and extended; sub-word stores are done as
// read-modify-write. Memory-side outputs decode only from registered state.
// Ports:
//  clk, rst_n                  clock, async active-low reset
//  req_valid/req_ready         request handshake (accept when both high)
//  req_write, req_size,        request: store flag, size, zero-extend flag,
//  req_unsigned, req_addr,     byte address, right-justified store data
//  req_wdata
//  resp_valid, resp_rdata,     one-cycle completion pulse, load data, error flag
//  resp_err
//  mem_read, mem_write,        memory strobes, word index, write word
//  mem_address, mem_write_data
//  mem_read_data               combinational read data from memory
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS    = 1024,
    parameter bit CHECK_BOUNDS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state_r;
    lsu_state_t  state_nxt_s;
    logic        write_r;
    logic        unsigned_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] wbuf_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic        accept_s;
    logic        range_s;
    logic        req_err_s;
    logic [31:0] load_data_s;
    logic [31:0] merged_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);

    // Request error classification, evaluated on the incoming request.
    always_comb begin
        if (CHECK_BOUNDS) begin
            range_s = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
        end else begin
            range_s = 1'b0;
        end
        req_err_s = bad_align(req_size, req_addr[1:0]) | range_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err_s) begin
                        state_nxt_s = ST_DONE;
                    end else if (!req_write) begin
                        state_nxt_s = ST_LOAD;
                    end else if (req_size == SZ_WORD) begin
                        state_nxt_s = ST_STORE;
                    end else begin
                        state_nxt_s = ST_RMW_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD:   state_nxt_s = ST_DONE;
            ST_RMW_RD: state_nxt_s = ST_STORE;
            ST_STORE:  state_nxt_s = ST_DONE;
            ST_DONE:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch; captured only on acceptance so later input changes cannot alter it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_r    <= 1'b0;
            unsigned_r <= 1'b0;
            size_r     <= 2'b00;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
        end else if (accept_s) begin
            write_r    <= req_write;
            unsigned_r <= req_unsigned;
            size_r     <= req_size;
            addr_r     <= req_addr;
            wdata_r    <= req_wdata;
        end
    end

    // Write buffer: holds store data directly for word stores, merged word after RMW read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbuf_r <= 32'h0000_0000;
        end else if (accept_s) begin
            wbuf_r <= req_wdata;
        end else if (state_r == ST_RMW_RD) begin
            wbuf_r <= merged_s;
        end
    end

    // Response registers, updated only on the edge that enters DONE so they hold in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_err_s) begin
                        rdata_r <= 32'h0000_0000;
                        err_r   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    rdata_r <= load_data_s;
                    err_r   <= 1'b0;
                end
                ST_STORE: begin
                    rdata_r <= 32'h0000_0000;
                    err_r   <= 1'b0;
                end
                default: begin
                    rdata_r <= rdata_r;
                    err_r   <= err_r;
                end
            endcase
        end
    end

    lsu_align u_align (
        .word_in     (mem_read_data),
        .addr_lo     (addr_r[1:0]),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .wdata       (wdata_r),
        .load_data   (load_data_s),
        .merged      (merged_s)
    );

    assign req_ready      = (state_r == ST_IDLE);
    assign resp_valid     = (state_r == ST_DONE);
    assign mem_read       = (state_r == ST_LOAD) || (state_r == ST_RMW_RD);
    assign mem_write      = (state_r == ST_STORE) && write_r;
    assign mem_address    = {2'b00, addr_r[31:2]};
    assign mem_write_data = wbuf_r;
    assign resp_rdata     = rdata_r;
    assign resp_err       = err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized requests
// compared against an arithmetic reference model of memory and load extension.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tb_mem [0:1023];
    logic [31:0] ref_mem [0:15];
    logic        pk_en = 1'b0;
    logic [9:0]  pk_idx = 10'h0;
    logic [31:0] pk_data = 32'h0;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, posedge write, plus a bench preload port.
    assign mem_read_data = (mem_address < 32'd1024) ? tb_mem[mem_address[9:0]] : 32'h0;
    always @(posedge clk) begin
        if (pk_en) tb_mem[pk_idx] <= pk_data;
        else if (mem_write && mem_address < 32'd1024) tb_mem[mem_address[9:0]] <= mem_write_data;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory strobes must never overlap and never occur while the unit is ready.
    always @(negedge clk) begin
        if (rst_n) begin
            check_value("rd_wr_excl", {31'b0, mem_read & mem_write}, 32'd0);
            check_value("idle_no_mem", {31'b0, req_ready & (mem_read | mem_write)}, 32'd0);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
               || ((a >> 2) >= 32'd1024);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
        logic [31:0] v;
        int sh;
        v = w;
        if (sz == 2'd0) begin
            sh = int'(a[1:0]) * 8;
            v = (w >> sh) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            sh = int'(a[1]) * 16;
            v = (w >> sh) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] m;
        int sh;
        if (sz == 2'd2) return d;
        sh = int'(a[1:0]) * 8;
        m = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~m) | ((d << sh) & m);
    endfunction

    task automatic poke(input int idx, input logic [31:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_idx = 10'(idx); pk_data = d;
        @(posedge clk); #1 pk_en = 1'b0;
        if (idx < 16) ref_mem[idx] = d;
    endtask

    // Issue one request and follow it to its response, observing memory strobes.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic rd_seen, output logic wr_seen);
        int guard;
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        check_value("accept_wait", (guard < 20) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom); req_write = ~w;
        lat = 1; rd_seen = 1'b0; wr_seen = 1'b0;
        @(negedge clk);
        while (!resp_valid && lat < 10) begin
            rd_seen |= mem_read; wr_seen |= mem_write;
            @(negedge clk); lat++;
        end
        check_value("resp_seen", {31'b0, resp_valid}, 32'd1);
        rd = resp_rdata; er = resp_err;
    endtask

    // Run a request and compare everything against the reference model.
    task automatic run_check(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd, e_rd;
        logic er, e_er, rs, ws;
        int lat, e_lat, idx;
        e_er = exp_err(sz, a);
        idx = int'(a[5:2]);
        e_rd = (w || e_er) ? 32'h0 : exp_load(ref_mem[idx], a, sz, u);
        e_lat = e_er ? 1 : ((!w || sz == 2'd2) ? 2 : 3);
        do_req(w, sz, u, a, d, rd, er, lat, rs, ws);
        check_value("rdata", rd, e_rd);
        check_value("err", {31'b0, er}, {31'b0, e_er});
        check_value("latency", 32'(lat), 32'(e_lat));
        check_value("mem_rd_use", {31'b0, rs}, {31'b0, !e_er && (!w || sz != 2'd2)});
        check_value("mem_wr_use", {31'b0, ws}, {31'b0, !e_er && w});
        @(negedge clk);
        check_value("resp_pulse", {31'b0, resp_valid}, 32'd0);
        check_value("rdata_hold", resp_rdata, e_rd);
        if (w && !e_er) begin
            ref_mem[idx] = exp_store(ref_mem[idx], a, sz, d);
            check_value("mem_word", tb_mem[idx], ref_mem[idx]);
        end
    endtask

    initial begin
        logic [4:0] rdy_seq, rsp_seq, mrd_seq, mwr_seq;
        logic [31:0] b2b_rdata;

        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // reset values
        check_value("rst_ready", {31'b0, req_ready}, 32'd1);
        check_value("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_value("rst_err", {31'b0, resp_err}, 32'd0);
        check_value("rst_mem_rd", {31'b0, mem_read}, 32'd0);
        check_value("rst_mem_wr", {31'b0, mem_write}, 32'd0);
        check_value("rst_rdata", resp_rdata, 32'h0);
        check_value("rst_addr", mem_address, 32'h0);
        check_value("rst_wdata", mem_write_data, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) poke(i, $urandom);

        // word store then word load
        run_check(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check_value("word4_store", tb_mem[4], 32'hDEAD_BEEF);
        run_check(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // byte loads at 0x13 of 0x8091A2B3
        poke(4, 32'h8091_A2B3);
        run_check(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check_value("byte_signed", exp_load(ref_mem[4], 32'h13, 2'd0, 1'b0), 32'hFFFF_FF80);
        run_check(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);

        // half store RMW
        poke(4, 32'h1122_3344);
        run_check(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_CAFE);
        check_value("half_rmw_word", tb_mem[4], 32'hCAFE_3344);

        // error cases
        run_check(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
        run_check(1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
        run_check(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        run_check(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
        run_check(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h55);

        // reset during RMW_RD of a byte store
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h15;
        req_wdata = 32'hAB; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_value("rmw_rd_active", {31'b0, mem_read}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_value("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        check_value("mid_rst_mem_rd", {31'b0, mem_read}, 32'd0);
        check_value("mid_rst_mem_wr", {31'b0, mem_write}, 32'd0);
        check_value("mid_rst_addr", mem_address, 32'h0);
        check_value("mid_rst_resp", {31'b0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        check_value("rmw_abort_word", tb_mem[5], ref_mem[5]);

        // back-to-back: load word 6 then word store to word 7 with req_valid held
        @(negedge clk);
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h18;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_write = 1'b1; req_addr = 32'h1C; req_wdata = 32'h1357_9BDF;
        b2b_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rdy_seq[i] = req_ready; rsp_seq[i] = resp_valid;
            mrd_seq[i] = mem_read; mwr_seq[i] = mem_write;
            if (i == 1) b2b_rdata = resp_rdata;
            if (i == 3) req_valid = 1'b0;
        end
        check_value("b2b_ready", {27'b0, rdy_seq}, 32'b00100);
        check_value("b2b_resp", {27'b0, rsp_seq}, 32'b10010);
        check_value("b2b_mem_rd", {27'b0, mrd_seq}, 32'b00001);
        check_value("b2b_mem_wr", {27'b0, mwr_seq}, 32'b01000);
        check_value("b2b_load", b2b_rdata, ref_mem[6]);
        ref_mem[7] = 32'h1357_9BDF;
        check_value("b2b_store", tb_mem[7], ref_mem[7]);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_1000) : 32'($urandom_range(0, 63));
            run_check(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
